// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
//
// Encodes decoded RV32I fields (R, LOAD, STORE, BRANCH) into 32-bit
// instruction words. Each accepted word is tagged with its byte address.
// Words are buffered in a 2-entry FIFO in front of the memory writer.
//
// Optional feature macro: RV_ENC_IMM_CHECK_EN
//   defined   : out_err flags LOAD/STORE immediates outside the signed
//               12-bit range and misaligned (odd) BRANCH offsets.
//   undefined : no check logic is built; out_err is tied to 0.
//
// Parameters
//   ADDR_W      width of the address counter and out_addr
//   START_ADDR  byte address of the first word after reset or flush
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous clear of FIFO and address counter
//   in_valid / in_ready      input handshake
//   in_cls                   00 R, 01 LOAD, 10 STORE, 11 BRANCH
//   in_funct3, in_funct7     function codes (funct7 used by R only)
//   in_rd, in_rs1, in_rs2    register indices
//   in_imm                   13-bit signed immediate
//   out_valid / out_ready    output handshake
//   out_instr, out_addr      head word and its byte address (0 when empty)
//   out_err                  immediate error flag of the head word

module rv_instr_encoder #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_cls,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err
);

   localparam logic [1:0] CLS_R      = 2'b00;
   localparam logic [1:0] CLS_LOAD   = 2'b01;
   localparam logic [1:0] CLS_STORE  = 2'b10;
   localparam logic [1:0] CLS_BRANCH = 2'b11;

   logic [1:0]        count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr0_q, instr0_d, instr1_q, instr1_d;
   logic [ADDR_W-1:0] waddr0_q, waddr0_d, waddr1_q, waddr1_d;

   logic [31:0] enc_word;
   logic        push, pop;
   logic        ld0_new, ld0_shift, ld1_new;

   assign in_ready  = (count_q != 2'd2) && !flush;
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      enc_word = '0;
      case (in_cls)
         CLS_R:      enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         CLS_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
         CLS_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                                 7'b0100011};
         CLS_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], 7'b1100011};
         default:    enc_word = '0;
      endcase
   end

   // Entry 0 is always the head. A push and pop together can only happen
   // at count 1 (push is blocked when full), so the new word lands in entry 0.
   always_comb begin
      ld0_new   = 1'b0;
      ld0_shift = 1'b0;
      ld1_new   = 1'b0;
      if (!flush) begin
         ld0_new   = push && ((count_q == 2'd0) || pop);
         ld0_shift = pop && !push && (count_q == 2'd2);
         ld1_new   = push && !pop && (count_q == 2'd1);
      end
   end

   always_comb begin
      count_d  = count_q;
      addr_d   = addr_q;
      instr0_d = instr0_q;
      instr1_d = instr1_q;
      waddr0_d = waddr0_q;
      waddr1_d = waddr1_q;

      if (flush) begin
         count_d = 2'd0;
         addr_d  = START_ADDR;
      end else begin
         count_d = 2'(count_q + {1'b0, push} - {1'b0, pop});
         if (push) begin
            addr_d = addr_q + ADDR_W'(4);
         end
      end

      if (ld0_new) begin
         instr0_d = enc_word;
         waddr0_d = addr_q;
      end else if (ld0_shift) begin
         instr0_d = instr1_q;
         waddr0_d = waddr1_q;
      end

      if (ld1_new) begin
         instr1_d = enc_word;
         waddr1_d = addr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= 2'd0;
         addr_q   <= START_ADDR;
         instr0_q <= '0;
         instr1_q <= '0;
         waddr0_q <= '0;
         waddr1_q <= '0;
      end else begin
         count_q  <= count_d;
         addr_q   <= addr_d;
         instr0_q <= instr0_d;
         instr1_q <= instr1_d;
         waddr0_q <= waddr0_d;
         waddr1_q <= waddr1_d;
      end
   end

   // Stale entry contents are masked so an empty FIFO reads as all zeros.
   assign out_instr = out_valid ? instr0_q : '0;
   assign out_addr  = out_valid ? waddr0_q : '0;

`ifdef RV_ENC_IMM_CHECK_EN
   logic imm_err;
   logic err0_q, err0_d, err1_q, err1_d;

   // LOAD/STORE: bits 12 and 11 differ -> value does not fit signed 12 bits.
   // BRANCH: offsets must be even.
   always_comb begin
      imm_err = 1'b0;
      case (in_cls)
         CLS_LOAD, CLS_STORE: imm_err = (in_imm[12] != in_imm[11]);
         CLS_BRANCH:          imm_err = in_imm[0];
         default:             imm_err = 1'b0;
      endcase
   end

   always_comb begin
      err0_d = err0_q;
      err1_d = err1_q;
      if (ld0_new) begin
         err0_d = imm_err;
      end else if (ld0_shift) begin
         err0_d = err1_q;
      end
      if (ld1_new) begin
         err1_d = imm_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err0_q <= 1'b0;
         err1_q <= 1'b0;
      end else begin
         err0_q <= err0_d;
         err1_q <= err1_d;
      end
   end

   assign out_err = out_valid && err0_q;
`else
   assign out_err = 1'b0;
`endif

endmodule
